// File: rtl/l2_fwd_stall.sv
// rtl/l2_fwd_stall.sv - one-entry hold/replay buffer for forwarded messages that conflict with an in-flight request
module l2_fwd_stall #(
  parameter int N_REQS    = 4,
  parameter int REQS_BITS = 2,
  parameter int MSG_BITS  = 3,
  parameter int ADDR_BITS = 28,
  parameter int ID_BITS   = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 peek_fwd_done,
  input  logic                 set_fwd_stall,
  input  logic                 clr_fwd_stall,
  input  logic                 set_fwd_stall_i,
  input  logic [REQS_BITS-1:0] fwd_stall_i_wr_data,
  input  logic [MSG_BITS-1:0]  fwd_msg_in,
  input  logic [ADDR_BITS-1:0] fwd_addr_in,
  input  logic [ID_BITS-1:0]   fwd_id_in,
  input  logic [N_REQS-1:0]    reqs_inv,
  input  logic                 replay_ready,
  output logic                 fwd_stall,
  output logic [REQS_BITS-1:0] fwd_stall_i,
  output logic                 replay_valid,
  output logic [MSG_BITS-1:0]  replay_msg,
  output logic [ADDR_BITS-1:0] replay_addr,
  output logic [ID_BITS-1:0]   replay_id,
  output logic [CNT_BITS-1:0]  stall_cycles
);

  typedef enum logic [1:0] {IDLE, STALLED, REPLAY} state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   capture;
  logic   inv_hit;

  // An out-of-range index never matches, so the stall simply persists.
  always_comb begin
    inv_hit = 1'b0;
    if (32'(fwd_stall_i) < N_REQS) inv_hit = reqs_inv[fwd_stall_i];
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // set has priority if l2_reqs ever drives both
        if (peek_fwd_done && set_fwd_stall) begin
          capture   = 1'b1;
          state_nxt = STALLED;
        end else if (peek_fwd_done && clr_fwd_stall) begin
          state_nxt = IDLE;
        end
      end
      STALLED: if (inv_hit) state_nxt = REPLAY;
      REPLAY:  if (replay_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fwd_stall_i  <= '0;
      replay_msg   <= '0;
      replay_addr  <= '0;
      replay_id    <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        replay_msg   <= fwd_msg_in;
        replay_addr  <= fwd_addr_in;
        replay_id    <= fwd_id_in;
        stall_cycles <= '0;
        if (set_fwd_stall_i) fwd_stall_i <= fwd_stall_i_wr_data;
      end else if (state == STALLED && stall_cycles != CNT_MAX) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

  // Flag spans capture+1 through the replay handshake cycle.
  assign fwd_stall    = (state != IDLE);
  assign replay_valid = (state == REPLAY);

endmodule

// File: tb/tb_l2_fwd_stall.sv
// tb/tb_l2_fwd_stall.sv - directed scoreboard bench for l2_fwd_stall
module tb_l2_fwd_stall;

  logic        clk = 1'b0;
  logic        rst;
  logic        peek_fwd_done, set_fwd_stall, clr_fwd_stall, set_fwd_stall_i;
  logic [1:0]  fwd_stall_i_wr_data;
  logic [2:0]  fwd_msg_in;
  logic [27:0] fwd_addr_in;
  logic [3:0]  fwd_id_in;
  logic [3:0]  reqs_inv;
  logic        replay_ready;

  logic        fwd_stall, replay_valid;
  logic [1:0]  fwd_stall_i;
  logic [2:0]  replay_msg;
  logic [27:0] replay_addr;
  logic [3:0]  replay_id;
  logic [15:0] stall_cycles;

  logic        s_fwd_stall, s_replay_valid;
  logic [1:0]  s_fwd_stall_i;
  logic [2:0]  s_replay_msg;
  logic [27:0] s_replay_addr;
  logic [3:0]  s_replay_id;
  logic [3:0]  s_stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  msg;
    logic [27:0] addr;
    logic [3:0]  id;
    logic [1:0]  idx;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  l2_fwd_stall dut (
    .clk(clk), .rst(rst), .peek_fwd_done(peek_fwd_done), .set_fwd_stall(set_fwd_stall),
    .clr_fwd_stall(clr_fwd_stall), .set_fwd_stall_i(set_fwd_stall_i),
    .fwd_stall_i_wr_data(fwd_stall_i_wr_data), .fwd_msg_in(fwd_msg_in),
    .fwd_addr_in(fwd_addr_in), .fwd_id_in(fwd_id_in), .reqs_inv(reqs_inv),
    .replay_ready(replay_ready), .fwd_stall(fwd_stall), .fwd_stall_i(fwd_stall_i),
    .replay_valid(replay_valid), .replay_msg(replay_msg), .replay_addr(replay_addr),
    .replay_id(replay_id), .stall_cycles(stall_cycles)
  );

  l2_fwd_stall #(.CNT_BITS(4)) dut_s (
    .clk(clk), .rst(rst), .peek_fwd_done(peek_fwd_done), .set_fwd_stall(set_fwd_stall),
    .clr_fwd_stall(clr_fwd_stall), .set_fwd_stall_i(set_fwd_stall_i),
    .fwd_stall_i_wr_data(fwd_stall_i_wr_data), .fwd_msg_in(fwd_msg_in),
    .fwd_addr_in(fwd_addr_in), .fwd_id_in(fwd_id_in), .reqs_inv(reqs_inv),
    .replay_ready(replay_ready), .fwd_stall(s_fwd_stall), .fwd_stall_i(s_fwd_stall_i),
    .replay_valid(s_replay_valid), .replay_msg(s_replay_msg), .replay_addr(s_replay_addr),
    .replay_id(s_replay_id), .stall_cycles(s_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    peek_fwd_done = 1'b0; set_fwd_stall = 1'b0; clr_fwd_stall = 1'b0;
    set_fwd_stall_i = 1'b0;
  endtask

  task automatic capture(input logic [2:0] m, input logic [27:0] a, input logic [3:0] id,
                         input logic [1:0] idx, input logic set_i, input logic [1:0] exp_idx);
    exp_t e;
    peek_fwd_done = 1'b1; set_fwd_stall = 1'b1; set_fwd_stall_i = set_i;
    fwd_stall_i_wr_data = idx; fwd_msg_in = m; fwd_addr_in = a; fwd_id_in = id;
    e.msg = m; e.addr = a; e.id = id; e.idx = exp_idx;
    sb.push_back(e);
    step();
    idle_inputs();
  endtask

  task automatic handshake(input string tag);
    exp_t e;
    check({tag, "_valid"}, 32'(replay_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_msg"}, 32'(replay_msg), 32'(e.msg));
      check({tag, "_addr"}, 32'(replay_addr), 32'(e.addr));
      check({tag, "_id"}, 32'(replay_id), 32'(e.id));
      check({tag, "_idx"}, 32'(fwd_stall_i), 32'(e.idx));
    end
    replay_ready = 1'b1;
    step();
    replay_ready = 1'b0;
    check({tag, "_stall_clr"}, 32'(fwd_stall), 32'd0);
    check({tag, "_valid_clr"}, 32'(replay_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    fwd_stall_i_wr_data = '0; fwd_msg_in = '0; fwd_addr_in = '0; fwd_id_in = '0;
    reqs_inv = 4'b1111; replay_ready = 1'b0;
    #3;
    check("rst_stall", 32'(fwd_stall), 32'd0);
    check("rst_valid", 32'(replay_valid), 32'd0);
    check("rst_addr", 32'(replay_addr), 32'd0);
    check("rst_cnt", 32'(stall_cycles), 32'd0);
    step();
    rst = 1'b1;
    step();

    // capture FWD_GETS at idx 2
    reqs_inv = 4'b1011;
    capture(3'd1, 28'h123, 4'h5, 2'd2, 1'b1, 2'd2);
    check("t1_stall", 32'(fwd_stall), 32'd1);
    check("t1_idx", 32'(fwd_stall_i), 32'd2);
    check("t1_valid", 32'(replay_valid), 32'd0);
    check("t1_cnt0", 32'(stall_cycles), 32'd0);

    // 10 cycles with entry 2 busy; a second peek must be ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        peek_fwd_done = 1'b1; set_fwd_stall = 1'b1; set_fwd_stall_i = 1'b1;
        fwd_stall_i_wr_data = 2'd0; fwd_msg_in = 3'd6; fwd_addr_in = 28'hFFF;
      end else begin
        idle_inputs();
      end
      step();
      check("t2_wait_valid", 32'(replay_valid), 32'd0);
    end
    idle_inputs();
    check("t2_cnt10", 32'(stall_cycles), 32'd10);
    reqs_inv = 4'b1111;
    step();
    check("t2_cnt11", 32'(stall_cycles), 32'd11);
    check("t2_valid", 32'(replay_valid), 32'd1);
    check("t2_addr", 32'(replay_addr), 32'h123);

    // controller back-pressure; entry refill does not cancel replay
    for (int i = 0; i < 3; i++) begin
      if (i == 1) reqs_inv = 4'b1011;
      step();
      check("t3_valid", 32'(replay_valid), 32'd1);
      check("t3_stall", 32'(fwd_stall), 32'd1);
      check("t3_addr", 32'(replay_addr), 32'h123);
      check("t3_cnt", 32'(stall_cycles), 32'd11);
    end
    handshake("t3_hs");
    check("t3_cnt_hold", 32'(stall_cycles), 32'd11);

    // clr path: no stall
    peek_fwd_done = 1'b1; clr_fwd_stall = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("t4_stall", 32'(fwd_stall), 32'd0);
      check("t4_valid", 32'(replay_valid), 32'd0);
      step();
    end

    // reset mid-stall
    reqs_inv = 4'b1101;
    capture(3'd2, 28'h456, 4'h9, 2'd1, 1'b1, 2'd1);
    check("t5_stall", 32'(fwd_stall), 32'd1);
    step();
    step();
    #2 rst = 1'b0;
    void'(sb.pop_back());
    #1;
    check("t5_rst_stall", 32'(fwd_stall), 32'd0);
    check("t5_rst_valid", 32'(replay_valid), 32'd0);
    check("t5_rst_addr", 32'(replay_addr), 32'd0);
    check("t5_rst_cnt", 32'(stall_cycles), 32'd0);
    check("t5_rst_idx", 32'(fwd_stall_i), 32'd0);
    step();
    rst = 1'b1;
    step();

    // new capture after reset, long stall for saturation
    reqs_inv = 4'b0111;
    capture(3'd3, 28'hABCDE, 4'hC, 2'd3, 1'b1, 2'd3);
    check("t5_new_stall", 32'(fwd_stall), 32'd1);
    check("t5_new_idx", 32'(fwd_stall_i), 32'd3);
    for (int i = 0; i < 20; i++) step();
    check("t6_cnt16", 32'(stall_cycles), 32'd20);
    check("t6_cnt4_sat", 32'(s_stall_cycles), 32'd15);
    reqs_inv = 4'b1111;
    step();
    check("t6_cnt4_frozen", 32'(s_stall_cycles), 32'd15);
    handshake("t6_hs");

    // capture without set_fwd_stall_i keeps the previous index
    capture(3'd4, 28'h777, 4'h1, 2'd0, 1'b0, 2'd3);
    check("t7_idx_kept", 32'(fwd_stall_i), 32'd3);
    step();
    handshake("t7_hs");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
